mem_arbiter: RTL and testbench

- Arbitrates two requesters onto one shared mem_interface instance (single-port, registered read).
- Port 0 is the fetch/stage side; port 1 is the exe/wb data side.
- Sequences each read through a wait/response FSM; writes complete in one cycle.
- Used wherever two pipeline stages share one memory instance (note/bitmap memories).

---
 rtl/mem_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates two requesters onto one single-port, registered-read memory
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req0_* / rsp0_*             port 0 (fetch/stage side) request handshake and read response
//   req1_* / rsp1_*             port 1 (exe/wb data side) request handshake and read response
//   mem_write_addr/mem_wr_data/mem_wr_enable, mem_read_addr   drive the shared memory
//   mem_rd_data                 read data, valid RD_LAT cycles after mem_read_addr
// Option: define MEM_ARB_FIXED_PRIO_EN so port 0 wins every conflict (round robin otherwise).
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic [ADDR_W-1:0] mem_write_addr,
  output logic [ADDR_W-1:0] mem_read_addr,
  output logic              mem_wr_enable,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data
);
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RD_WAIT = 2'd1;
  localparam logic [1:0] S_RSP     = 2'd2;
  // The counter starts at RD_LAT-1 so the capture lands exactly RD_LAT cycles after the address.
  localparam logic [2:0] CNT_INIT  = 3'(RD_LAT - 1);
  logic [1:0]        r_state;
  logic              r_last_grant;
  logic              r_owner;
  logic [2:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_rsp0_valid;
  logic              r_rsp1_valid;
  logic [DATA_W-1:0] r_rsp0_rdata;
  logic [DATA_W-1:0] r_rsp1_rdata;
  logic              w_gnt1;
  logic              w_acc;
  logic              w_we;
  logic              w_wr;
  logic              w_rd;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
`ifdef MEM_ARB_FIXED_PRIO_EN
  assign w_gnt1 = req1_valid && !req0_valid;
`else
  // Port 1 wins a conflict only when port 0 was granted last.
  assign w_gnt1 = req1_valid && (!req0_valid || !r_last_grant);
`endif
  assign w_acc      = (r_state == S_IDLE) && (req0_valid || req1_valid);
  assign w_we       = w_gnt1 ? req1_we : req0_we;
  assign w_addr     = w_gnt1 ? req1_addr : req0_addr;
  assign w_wdata    = w_gnt1 ? req1_wdata : req0_wdata;
  assign w_wr       = w_acc && w_we;
  assign w_rd       = w_acc && !w_we;
  assign req0_ready = w_acc && !w_gnt1;
  assign req1_ready = w_acc && w_gnt1;
  assign mem_wr_enable  = w_wr;
  assign mem_write_addr = w_wr ? w_addr : '0;
  assign mem_wr_data    = w_wr ? w_wdata : '0;
  // Keep the read address stable for the whole wait so the memory sees it every cycle.
  assign mem_read_addr  = w_rd ? w_addr : (r_state == S_RD_WAIT) ? r_addr : '0;
  assign rsp0_valid = r_rsp0_valid;
  assign rsp1_valid = r_rsp1_valid;
  assign rsp0_rdata = r_rsp0_rdata;
  assign rsp1_rdata = r_rsp1_rdata;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_cnt        <= '0;
      r_addr       <= '0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp0_rdata <= '0;
      r_rsp1_rdata <= '0;
    end else begin
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_acc) r_last_grant <= w_gnt1;
          if (w_rd) begin
            r_addr  <= w_addr;
            r_owner <= w_gnt1;
            r_cnt   <= CNT_INIT;
            r_state <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (r_cnt != 3'd0) begin
            r_cnt <= r_cnt - 3'd1;
          end else begin
            if (r_owner) begin
              r_rsp1_valid <= 1'b1;
              r_rsp1_rdata <= mem_rd_data;
            end else begin
              r_rsp0_valid <= 1'b1;
              r_rsp0_rdata <= mem_rd_data;
            end
            r_state <= S_RSP;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with RD_LAT=1 (instance 0) and RD_LAT=3 (instance 1)
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  logic        req0_valid [2], req0_we [2], req1_valid [2], req1_we [2];
  logic [15:0] req0_addr [2], req0_wdata [2], req1_addr [2], req1_wdata [2];
  logic        req0_ready [2], req1_ready [2], rsp0_valid [2], rsp1_valid [2], mem_wr_enable [2];
  logic [15:0] rsp0_rdata [2], rsp1_rdata [2], mem_write_addr [2], mem_read_addr [2];
  logic [15:0] mem_wr_data [2], mem_rd_data [2];
  typedef struct {
    bit          port;
    logic [15:0] data;
    int          due;
  } exp_t;
  exp_t exp_q[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_dut
      localparam int LAT = (g == 0) ? 1 : 3;
      logic [15:0] mem [512];
      logic [15:0] pipe [3];
      always @(posedge clk) begin
        if (mem_wr_enable[g]) mem[mem_write_addr[g][8:0]] <= mem_wr_data[g];
        pipe[0] <= mem[mem_read_addr[g][8:0]];
        pipe[1] <= pipe[0];
        pipe[2] <= pipe[1];
      end
      assign mem_rd_data[g] = pipe[LAT-1];
      mem_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(LAT)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid[g]), .req0_we(req0_we[g]), .req0_addr(req0_addr[g]),
        .req0_wdata(req0_wdata[g]), .req0_ready(req0_ready[g]),
        .rsp0_valid(rsp0_valid[g]), .rsp0_rdata(rsp0_rdata[g]),
        .req1_valid(req1_valid[g]), .req1_we(req1_we[g]), .req1_addr(req1_addr[g]),
        .req1_wdata(req1_wdata[g]), .req1_ready(req1_ready[g]),
        .rsp1_valid(rsp1_valid[g]), .rsp1_rdata(rsp1_rdata[g]),
        .mem_write_addr(mem_write_addr[g]), .mem_read_addr(mem_read_addr[g]),
        .mem_wr_enable(mem_wr_enable[g]), .mem_wr_data(mem_wr_data[g]),
        .mem_rd_data(mem_rd_data[g])
      );
    end
  endgenerate
  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if ({req0_ready[k], req1_ready[k], rsp0_valid[k], rsp1_valid[k], mem_wr_enable[k]} !== 5'b0) begin
        miscompares++;
        $display("FAIL reset_ctrl[%0d]: rdy0/rdy1/rsp0/rsp1/we=%b, want 00000", k,
                 {req0_ready[k], req1_ready[k], rsp0_valid[k], rsp1_valid[k], mem_wr_enable[k]});
      end
      vectors++;
      if ({rsp0_rdata[k], rsp1_rdata[k], mem_read_addr[k], mem_write_addr[k], mem_wr_data[k]} !== 80'b0) begin
        miscompares++;
        $display("FAIL reset_data[%0d]: rd0=%h rd1=%h ra=%h wa=%h wd=%h, want all 0", k,
                 rsp0_rdata[k], rsp1_rdata[k], mem_read_addr[k], mem_write_addr[k], mem_wr_data[k]);
      end
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if ({req0_ready[k], req1_ready[k], rsp0_valid[k], rsp1_valid[k]} !== 4'b0) begin
          miscompares++;
          $display("FAIL idle_quiet[%0d]: rdy0/rdy1/rsp0/rsp1=%b, want 0000", k,
                   {req0_ready[k], req1_ready[k], rsp0_valid[k], rsp1_valid[k]});
        end
      end
    end
  endtask
  task automatic test_write_pair();
    @(negedge clk);
    req0_valid[0] = 1'b1; req0_we[0] = 1'b1; req0_addr[0] = 16'h0020; req0_wdata[0] = 16'h1111;
    req1_valid[0] = 1'b1; req1_we[0] = 1'b1; req1_addr[0] = 16'h0021; req1_wdata[0] = 16'h2222;
    #1;
    vectors++;
    if ({req0_ready[0], req1_ready[0], mem_wr_enable[0], mem_write_addr[0], mem_wr_data[0]} !==
        {3'b101, 16'h0020, 16'h1111}) begin
      miscompares++;
      $display("FAIL wr_first: rdy=%b%b we=%b wa=%h wd=%h, want rdy=10 we=1 wa=0020 wd=1111",
               req0_ready[0], req1_ready[0], mem_wr_enable[0], mem_write_addr[0], mem_wr_data[0]);
    end
    @(negedge clk);
    req0_valid[0] = 1'b0;
    #1;
    vectors++;
    if ({req0_ready[0], req1_ready[0], mem_wr_enable[0], mem_write_addr[0], mem_wr_data[0]} !==
        {3'b011, 16'h0021, 16'h2222}) begin
      miscompares++;
      $display("FAIL wr_second: rdy=%b%b we=%b wa=%h wd=%h, want rdy=01 we=1 wa=0021 wd=2222",
               req0_ready[0], req1_ready[0], mem_wr_enable[0], mem_write_addr[0], mem_wr_data[0]);
    end
    @(negedge clk);
    req1_valid[0] = 1'b0;
    req0_valid[0] = 1'b1; req0_addr[0] = 16'h0010; req0_wdata[0] = 16'hBEEF;
    #1;
    vectors++;
    if ({req0_ready[0], req1_ready[0], mem_wr_enable[0], mem_write_addr[0]} !== {3'b101, 16'h0010}) begin
      miscompares++;
      $display("FAIL wr_third: rdy=%b%b we=%b wa=%h, want rdy=10 we=1 wa=0010",
               req0_ready[0], req1_ready[0], mem_wr_enable[0], mem_write_addr[0]);
    end
    @(negedge clk);
    req0_valid[0] = 1'b0; req0_we[0] = 1'b0; req1_we[0] = 1'b0;
  endtask
  task automatic test_read_lat1();
    exp_t e;
    logic [15:0] got;
    @(negedge clk);
    req0_valid[0] = 1'b1; req0_we[0] = 1'b0; req0_addr[0] = 16'h0010;
    #1;
    vectors++;
    if ({req0_ready[0], req1_ready[0], mem_wr_enable[0], mem_read_addr[0]} !== {3'b100, 16'h0010}) begin
      miscompares++;
      $display("FAIL rd1_accept: rdy=%b%b we=%b ra=%h, want rdy=10 we=0 ra=0010",
               req0_ready[0], req1_ready[0], mem_wr_enable[0], mem_read_addr[0]);
    end
    exp_q.push_back('{1'b0, 16'hBEEF, cyc + 2});
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      req0_valid[0] = 1'b0;
      #1;
      if (rsp0_valid[0] || rsp1_valid[0]) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL rd1_rsp_extra: cyc=%0d rsp0=%b rsp1=%b, want no response", cyc, rsp0_valid[0], rsp1_valid[0]);
        end else begin
          e = exp_q.pop_front();
          got = e.port ? rsp1_rdata[0] : rsp0_rdata[0];
          if ({rsp1_valid[0], rsp0_valid[0]} !== {e.port, !e.port} || got !== e.data || cyc != e.due) begin
            miscompares++;
            $display("FAIL rd1_rsp: cyc=%0d rsp1/0=%b%b data=%h, want cyc=%0d port=%0d data=%h",
                     cyc, rsp1_valid[0], rsp0_valid[0], got, e.due, e.port, e.data);
          end
        end
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL rd1_rsp_missing: %0d outstanding, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask
  task automatic test_rr_reads();
    exp_t e;
    logic [15:0] got;
    bit g1;
    int n = 0;
    int last_acc = -1;
`ifdef MEM_ARB_FIXED_PRIO_EN
    bit seq [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    int n0 = 3;
`else
    bit seq [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    int n0 = 4;
`endif
    req0_we[0] = 1'b0; req0_addr[0] = 16'h0020;
    req1_we[0] = 1'b0; req1_addr[0] = 16'h0021;
    for (int i = 0; i < 30 && (n < 4 || exp_q.size() != 0); i++) begin
      @(negedge clk);
      req0_valid[0] = n < n0;
      req1_valid[0] = n < 4;
      #1;
      vectors++;
      if (req0_ready[0] && req1_ready[0]) begin
        miscompares++;
        $display("FAIL rr_both_ready: cyc=%0d rdy=11, want at most one", cyc);
      end
      if (req0_ready[0] || req1_ready[0]) begin
        g1 = req1_ready[0];
        vectors++;
        if (g1 !== seq[n]) begin
          miscompares++;
          $display("FAIL rr_grant: accept %0d port=%0d, want port=%0d", n, g1, seq[n]);
        end
        if (last_acc >= 0) begin
          vectors++;
          if (cyc - last_acc != 3) begin
            miscompares++;
            $display("FAIL rr_spacing: accept %0d after %0d cycles, want 3", n, cyc - last_acc);
          end
        end
        exp_q.push_back('{g1, g1 ? 16'h2222 : 16'h1111, cyc + 2});
        last_acc = cyc;
        n++;
      end
      if (rsp0_valid[0] || rsp1_valid[0]) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL rr_rsp_extra: cyc=%0d rsp0=%b rsp1=%b, want no response", cyc, rsp0_valid[0], rsp1_valid[0]);
        end else begin
          e = exp_q.pop_front();
          got = e.port ? rsp1_rdata[0] : rsp0_rdata[0];
          if ({rsp1_valid[0], rsp0_valid[0]} !== {e.port, !e.port} || got !== e.data || cyc != e.due) begin
            miscompares++;
            $display("FAIL rr_rsp: cyc=%0d rsp1/0=%b%b data=%h, want cyc=%0d port=%0d data=%h",
                     cyc, rsp1_valid[0], rsp0_valid[0], got, e.due, e.port, e.data);
          end
        end
      end
    end
    req0_valid[0] = 1'b0;
    req1_valid[0] = 1'b0;
    vectors++;
    if (n != 4 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL rr_incomplete: accepts=%0d outstanding=%0d, want 4 and 0", n, exp_q.size());
      exp_q.delete();
    end
  endtask
  task automatic test_lat3();
    exp_t e;
    logic [15:0] got;
    int t;
    bit acc0 = 1'b0;
    @(negedge clk);
    req1_valid[1] = 1'b1; req1_we[1] = 1'b1; req1_addr[1] = 16'h0100; req1_wdata[1] = 16'h5A5A;
    #1;
    vectors++;
    if ({req0_ready[1], req1_ready[1], mem_wr_enable[1], mem_write_addr[1], mem_wr_data[1]} !==
        {3'b011, 16'h0100, 16'h5A5A}) begin
      miscompares++;
      $display("FAIL l3_write: rdy=%b%b we=%b wa=%h wd=%h, want rdy=01 we=1 wa=0100 wd=5a5a",
               req0_ready[1], req1_ready[1], mem_wr_enable[1], mem_write_addr[1], mem_wr_data[1]);
    end
    @(negedge clk);
    req1_we[1] = 1'b0;
    #1;
    vectors++;
    if ({req1_ready[1], mem_read_addr[1], mem_wr_enable[1]} !== {1'b1, 16'h0100, 1'b0}) begin
      miscompares++;
      $display("FAIL l3_accept: rdy1=%b ra=%h we=%b, want rdy1=1 ra=0100 we=0",
               req1_ready[1], mem_read_addr[1], mem_wr_enable[1]);
    end
    t = cyc;
    exp_q.push_back('{1'b1, 16'h5A5A, t + 4});
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      req1_valid[1] = 1'b0;
      req0_valid[1] = !acc0; req0_we[1] = 1'b0; req0_addr[1] = 16'h0100;
      #1;
      if (i == 2) begin
        vectors++;
        if (mem_read_addr[1] !== 16'h0100) begin
          miscompares++;
          $display("FAIL l3_hold_addr: ra=%h, want 0100", mem_read_addr[1]);
        end
      end
      if (req0_ready[1]) begin
        vectors++;
        if (cyc != t + 5) begin
          miscompares++;
          $display("FAIL l3_pending_accept: accepted at T+%0d, want T+5", cyc - t);
        end
        exp_q.push_back('{1'b0, 16'h5A5A, cyc + 4});
        acc0 = 1'b1;
      end
      if (rsp0_valid[1] || rsp1_valid[1]) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL l3_rsp_extra: cyc=%0d rsp0=%b rsp1=%b, want no response", cyc, rsp0_valid[1], rsp1_valid[1]);
        end else begin
          e = exp_q.pop_front();
          got = e.port ? rsp1_rdata[1] : rsp0_rdata[1];
          if ({rsp1_valid[1], rsp0_valid[1]} !== {e.port, !e.port} || got !== e.data || cyc != e.due) begin
            miscompares++;
            $display("FAIL l3_rsp: cyc=%0d rsp1/0=%b%b data=%h, want cyc=%0d port=%0d data=%h",
                     cyc, rsp1_valid[1], rsp0_valid[1], got, e.due, e.port, e.data);
          end
        end
      end
    end
    req0_valid[1] = 1'b0;
    vectors++;
    if (!acc0 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL l3_incomplete: acc0=%b outstanding=%0d, want 1 and 0", acc0, exp_q.size());
      exp_q.delete();
    end
  endtask
  task automatic test_reset_mid();
    exp_t e;
    logic [15:0] got;
    @(negedge clk);
    req0_valid[1] = 1'b1; req0_we[1] = 1'b0; req0_addr[1] = 16'h0100;
    #1;
    vectors++;
    if (req0_ready[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL rm_accept: rdy0=%b, want 1", req0_ready[1]);
    end
    @(negedge clk);
    req0_valid[1] = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({rsp0_valid[1], rsp1_valid[1], mem_read_addr[1], rsp0_rdata[1], rsp1_rdata[1]} !== 50'b0) begin
      miscompares++;
      $display("FAIL rm_async: rsp=%b%b ra=%h rd0=%h rd1=%h, want all 0",
               rsp0_valid[1], rsp1_valid[1], mem_read_addr[1], rsp0_rdata[1], rsp1_rdata[1]);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    req1_valid[1] = 1'b1; req1_we[1] = 1'b0; req1_addr[1] = 16'h0100;
    #1;
    vectors++;
    if ({req0_ready[1], req1_ready[1]} !== 2'b01) begin
      miscompares++;
      $display("FAIL rm_first_accept: rdy=%b%b, want 01", req0_ready[1], req1_ready[1]);
    end
    exp_q.push_back('{1'b1, 16'h5A5A, cyc + 4});
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      req1_valid[1] = 1'b0;
      #1;
      if (rsp0_valid[1] || rsp1_valid[1]) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL rm_rsp_extra: cyc=%0d rsp0=%b rsp1=%b, want no response", cyc, rsp0_valid[1], rsp1_valid[1]);
        end else begin
          e = exp_q.pop_front();
          got = e.port ? rsp1_rdata[1] : rsp0_rdata[1];
          if ({rsp1_valid[1], rsp0_valid[1]} !== {e.port, !e.port} || got !== e.data || cyc != e.due) begin
            miscompares++;
            $display("FAIL rm_rsp: cyc=%0d rsp1/0=%b%b data=%h, want cyc=%0d port=%0d data=%h",
                     cyc, rsp1_valid[1], rsp0_valid[1], got, e.due, e.port, e.data);
          end
        end
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL rm_rsp_missing: %0d outstanding, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask
  initial begin
    for (int k = 0; k < 2; k++) begin
      req0_valid[k] = 1'b0; req0_we[k] = 1'b0; req0_addr[k] = '0; req0_wdata[k] = '0;
      req1_valid[k] = 1'b0; req1_we[k] = 1'b0; req1_addr[k] = '0; req1_wdata[k] = '0;
    end
    test_reset();
    test_write_pair();
    test_read_lat1();
    test_rr_reads();
    test_lat3();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end
endmodule
